// File: rtl/avmm_sha3_master_if.sv
// Bundle of the message stream, the digest stream and the Avalon-MM bus used by avmm_sha3_master.
// The master modport is the block's own view; the slave modport is the view from the hasher/stream side.
interface avmm_sha3_master_if #(
  parameter int ADDR_W = 5
) ();
  logic              msg_valid;
  logic [31:0]       msg_data;
  logic              msg_last;
  logic              msg_ready;

  logic              dig_valid;
  logic [31:0]       dig_data;
  logic              dig_last;
  logic              dig_ready;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    input  msg_valid, msg_data, msg_last,
    output msg_ready,
    output dig_valid, dig_data, dig_last,
    input  dig_ready,
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    output msg_valid, msg_data, msg_last,
    input  msg_ready,
    input  dig_valid, dig_data, dig_last,
    output dig_ready,
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/avmm_sha3_master.sv
// Avalon-MM master that feeds message words into the SHA-3 wrapper, finalises, polls STATUS and streams the digest.
// Optional macro SHA3_POLL_TIMEOUT_EN adds POLL_LIMIT: too many not-done STATUS reads raise sticky err and abandon the message.
module avmm_sha3_master #(
  parameter int ADDR_W       = 5,
  parameter int DIGEST_WORDS = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int POLL_GAP     = 8
`ifdef SHA3_POLL_TIMEOUT_EN
  , parameter int POLL_LIMIT = 1024
`endif
) (
  input  logic               clk,
  input  logic               reset,
  avmm_sha3_master_if.master bus,
  output logic               busy,
  output logic               err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(DIGEST_WORDS) + 1;
  localparam int GAP_W = $clog2(POLL_GAP) + 1;

  localparam logic [PTR_W:0]      FULL_CNT    = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(DIGEST_WORDS - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(POLL_GAP - 1);
  localparam logic [ADDR_W-1:0]   ADDR_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0]   ADDR_DATA   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]   ADDR_STATUS = ADDR_W'(2);
  localparam logic [ADDR_W-1:0]   ADDR_DIGEST = ADDR_W'(16);

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_FIN, S_GAP, S_POLL, S_RDIG, S_OUT
  } state_t;

  // ---------------------------------------------------------------- input FIFO
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             msg_ready_q;
  logic             push, pop, fifo_empty;
  entry_t           head;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q, wr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       dig_data_q;
  logic              dig_valid_q, dig_last_q;
  logic [IDX_W-1:0]  idx_q;
  logic [GAP_W-1:0]  gap_q;
  logic              xfer_done;

  assign push       = bus.msg_valid && msg_ready_q;
  assign pop        = (state_q == S_DATA) && wr_q && !bus.avm_waitrequest;
  assign fifo_empty = (count_q == '0);
  assign head       = mem[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  // NOTE: storage is deliberately left without reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{last: bus.msg_last, data: bus.msg_data};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      msg_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      msg_ready_q <= (count_d != FULL_CNT);
    end
  end

  // ---------------------------------------------------------------- control FSM
  assign xfer_done = (rd_q || wr_q) && !bus.avm_waitrequest;

`ifdef SHA3_POLL_TIMEOUT_EN
  localparam int PC_W = $clog2(POLL_LIMIT + 1);
  localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_LIMIT - 1);
  logic [PC_W-1:0] poll_cnt_q;
  logic            err_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      dig_data_q  <= '0;
      dig_valid_q <= 1'b0;
      dig_last_q  <= 1'b0;
      idx_q       <= '0;
      gap_q       <= '0;
`ifdef SHA3_POLL_TIMEOUT_EN
      poll_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_q <= S_START;
            wr_q    <= 1'b1;
            addr_q  <= ADDR_CTRL;
            wdata_q <= 32'h1;
          end
        end
        S_START: begin
          idx_q <= '0;
`ifdef SHA3_POLL_TIMEOUT_EN
          poll_cnt_q <= '0;
`endif
          if (xfer_done) begin
            wr_q    <= 1'b0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          // A low wr_q doubles as the mandatory idle cycle after each completion.
          if (wr_q) begin
            if (!bus.avm_waitrequest) begin
              wr_q <= 1'b0;
              if (head.last) state_q <= S_FIN;
            end
          end else if (!fifo_empty) begin
            wr_q    <= 1'b1;
            addr_q  <= ADDR_DATA;
            wdata_q <= head.data;
          end
        end
        S_FIN: begin
          if (wr_q) begin
            if (!bus.avm_waitrequest) begin
              wr_q    <= 1'b0;
              gap_q   <= '0;
              state_q <= S_GAP;
            end
          end else begin
            wr_q    <= 1'b1;
            addr_q  <= ADDR_CTRL;
            wdata_q <= 32'h2;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            rd_q    <= 1'b1;
            addr_q  <= ADDR_STATUS;
            state_q <= S_POLL;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_POLL: begin
          if (xfer_done) begin
            rd_q  <= 1'b0;
            gap_q <= '0;
            if (bus.avm_readdata[0]) begin
              state_q <= S_RDIG;
`ifdef SHA3_POLL_TIMEOUT_EN
            end else if (poll_cnt_q == POLL_LAST) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              poll_cnt_q <= poll_cnt_q + 1'b1;
              state_q    <= S_GAP;
`else
            end else begin
              state_q <= S_GAP;
`endif
            end
          end
        end
        S_RDIG: begin
          if (rd_q) begin
            if (!bus.avm_waitrequest) begin
              rd_q        <= 1'b0;
              dig_data_q  <= bus.avm_readdata;
              dig_valid_q <= 1'b1;
              dig_last_q  <= (idx_q == LAST_IDX);
              state_q     <= S_OUT;
            end
          end else begin
            rd_q   <= 1'b1;
            addr_q <= ADDR_DIGEST + ADDR_W'(idx_q);
          end
        end
        S_OUT: begin
          if (bus.dig_ready) begin
            dig_valid_q <= 1'b0;
            dig_last_q  <= 1'b0;
            idx_q       <= idx_q + 1'b1;
            state_q     <= (idx_q == LAST_IDX) ? S_IDLE : S_RDIG;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.msg_ready     = msg_ready_q;
  assign bus.dig_valid     = dig_valid_q;
  assign bus.dig_data      = dig_data_q;
  assign bus.dig_last      = dig_last_q;
  assign bus.avm_address   = addr_q;
  assign bus.avm_read      = rd_q;
  assign bus.avm_write     = wr_q;
  assign bus.avm_writedata = wdata_q;
  assign busy              = (state_q != S_IDLE);

`ifdef SHA3_POLL_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_avmm_sha3_master.sv
// Self-checking bench for avmm_sha3_master: a behavioural hasher slave and digest consumer with random stalls,
// and a transaction-level model of the expected bus sequence and digest stream per message.
`timescale 1ns/1ps
module tb_avmm_sha3_master;
  localparam int ADDR_W       = 5;
  localparam int DIGEST_WORDS = 16;
  localparam int FIFO_DEPTH   = 4;
  localparam int POLL_GAP     = 8;
`ifdef SHA3_POLL_TIMEOUT_EN
  localparam int POLL_LIMIT   = 5;
`endif

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } xact_t;

  logic clk;
  logic reset;
  logic busy;
  logic err;

  avmm_sha3_master_if #(.ADDR_W(ADDR_W)) bus ();

  avmm_sha3_master #(
    .ADDR_W(ADDR_W), .DIGEST_WORDS(DIGEST_WORDS), .FIFO_DEPTH(FIFO_DEPTH), .POLL_GAP(POLL_GAP)
`ifdef SHA3_POLL_TIMEOUT_EN
    , .POLL_LIMIT(POLL_LIMIT)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave/consumer configuration, written by the test sequence.
  int          stall_addr    = -1;
  int          stall_len     = 0;
  int          rand_wait_pct = 0;
  int          ready_pct     = 100;
  int          done_after    = 1;
  int          hold_idx      = -1;
  int          hold_len      = 0;
  logic [31:0] dig_tab [DIGEST_WORDS];

  // Observations collected by the slave/consumer.
  xact_t       obs_q[$];
  logic [31:0] dig_got[$];
  logic        last_got[$];
  int          status_start_cyc[$];
  int          max_hold = 0;
  int          cyc = 0;

  // Hasher slave and digest consumer: decides each cycle's waitrequest/readdata/dig_ready at posedge+1.
  initial begin : bus_proc
    int stall_left, polls, held, hold_left, a;
    bit prev_wait, prev_done, prev_dwait, wait_now, done_now;
    logic prev_rd, prev_wr, prev_dlast;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0] prev_wdata, prev_ddata;
    stall_left = 0; polls = 0; held = 0; hold_left = 0;
    prev_wait = 0; prev_done = 0; prev_dwait = 0;
    prev_rd = 0; prev_wr = 0; prev_dlast = 0; prev_addr = '0; prev_wdata = '0; prev_ddata = '0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = '0;
    bus.dig_ready       = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!reset) begin
        stall_left = 0; hold_left = 0; held = 0;
        prev_wait = 0; prev_done = 0; prev_dwait = 0;
        bus.avm_waitrequest = 1'b0;
        bus.dig_ready       = 1'b0;
        continue;
      end
      if (prev_wait) begin
        check("hold_cmd", 64'({bus.avm_read, bus.avm_write}), 64'({prev_rd, prev_wr}));
        check("hold_addr", 64'(bus.avm_address), 64'(prev_addr));
        if (prev_wr) check("hold_wdata", 64'(bus.avm_writedata), 64'(prev_wdata));
      end
      if (prev_done) check("cmd_gap", 64'({bus.avm_read, bus.avm_write}), 64'(0));
      if (bus.avm_read || bus.avm_write)
        check("rd_wr_excl", 64'(bus.avm_read & bus.avm_write), 64'(0));

      wait_now = 0;
      done_now = 0;
      if (bus.avm_read || bus.avm_write) begin
        a = int'(bus.avm_address);
        if (!prev_wait) begin
          held = 0;
          if (a == stall_addr) begin
            stall_left = stall_len;
            stall_addr = -1;
          end else if (int'($urandom_range(99)) < rand_wait_pct) begin
            stall_left = int'($urandom_range(3, 1));
          end
          if (bus.avm_read && a == 2) status_start_cyc.push_back(cyc);
        end
        held++;
        if (stall_left > 0) begin
          stall_left--;
          wait_now = 1;
          bus.avm_waitrequest = 1'b1;
          bus.avm_readdata    = $urandom;
        end else begin
          done_now = 1;
          bus.avm_waitrequest = 1'b0;
          if (held > max_hold) max_hold = held;
          if (bus.avm_write) begin
            obs_q.push_back('{wr: 1'b1, addr: 8'(a), data: bus.avm_writedata});
            if (a == 0 && bus.avm_writedata == 32'h1) polls = 0;
            bus.avm_readdata = $urandom;
          end else begin
            obs_q.push_back('{wr: 1'b0, addr: 8'(a), data: 32'h0});
            if (a == 2) begin
              polls++;
              bus.avm_readdata = (polls >= done_after) ? 32'h0000_0001 : 32'hFFFF_FFFE;
            end else if (a >= 16 && a < 16 + DIGEST_WORDS) begin
              bus.avm_readdata = dig_tab[a-16];
            end else begin
              bus.avm_readdata = $urandom;
            end
          end
        end
      end else begin
        bus.avm_waitrequest = 1'($urandom_range(1));
        bus.avm_readdata    = $urandom;
      end
      prev_wait  = wait_now;
      prev_done  = done_now;
      prev_rd    = bus.avm_read;
      prev_wr    = bus.avm_write;
      prev_addr  = bus.avm_address;
      prev_wdata = bus.avm_writedata;

      if (prev_dwait) begin
        check("dig_hold_valid", 64'(bus.dig_valid), 64'(1));
        check("dig_hold_data", 64'(bus.dig_data), 64'(prev_ddata));
        check("dig_hold_last", 64'(bus.dig_last), 64'(prev_dlast));
      end
      prev_dwait = 0;
      if (bus.dig_valid) begin
        check("no_read_in_out", 64'(bus.avm_read), 64'(0));
        if (hold_left == 0 && hold_idx == dig_got.size()) begin
          hold_left = hold_len;
          hold_idx  = -1;
        end
        if (hold_left > 0) begin
          hold_left--;
          bus.dig_ready = 1'b0;
        end else begin
          bus.dig_ready = (int'($urandom_range(99)) < ready_pct);
        end
        if (bus.dig_ready) begin
          dig_got.push_back(bus.dig_data);
          last_got.push_back(bus.dig_last);
        end else begin
          prev_dwait = 1;
          prev_ddata = bus.dig_data;
          prev_dlast = bus.dig_last;
        end
      end else begin
        bus.dig_ready = 1'($urandom_range(1));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_read"},   64'(bus.avm_read),      64'(0));
    check({tag, "_write"},  64'(bus.avm_write),     64'(0));
    check({tag, "_addr"},   64'(bus.avm_address),   64'(0));
    check({tag, "_wdata"},  64'(bus.avm_writedata), 64'(0));
    check({tag, "_mready"}, 64'(bus.msg_ready),     64'(0));
    check({tag, "_dvalid"}, 64'(bus.dig_valid),     64'(0));
    check({tag, "_ddata"},  64'(bus.dig_data),      64'(0));
    check({tag, "_dlast"},  64'(bus.dig_last),      64'(0));
    check({tag, "_busy"},   64'(busy),              64'(0));
    check({tag, "_err"},    64'(err),               64'(0));
  endtask

  task automatic push_word(input logic [31:0] d, input logic last);
    bit ok;
    ok = 0;
    bus.msg_valid = 1'b1;
    bus.msg_data  = d;
    bus.msg_last  = last;
    for (int t = 0; t < 3000; t++) begin
      ok = bus.msg_ready;
      @(posedge clk); #2;
      if (ok) break;
    end
    bus.msg_valid = 1'b0;
    if (!ok) check("push_timeout", 64'(ok), 64'(1));
  endtask

  task automatic start_message(input int da);
    for (int i = 0; i < DIGEST_WORDS; i++) dig_tab[i] = $urandom;
    done_after = da;
    obs_q.delete();
    dig_got.delete();
    last_got.delete();
    status_start_cyc.delete();
    max_hold = 0;
  endtask

  // Reference: CTRL=1, one DATA write per word, CTRL=2, da STATUS reads, then one read per digest word.
  task automatic finish_message(input string tag, input logic [31:0] words[$], input int da);
    xact_t exp_q[$];
    bit ok;
    ok = 0;
    for (int t = 0; t < 5000; t++) begin
      if (dig_got.size() == DIGEST_WORDS && !busy) begin
        ok = 1;
        break;
      end
      @(posedge clk); #2;
    end
    if (!ok) check({tag, "_done_timeout"}, 64'(ok), 64'(1));
    exp_q.push_back('{wr: 1'b1, addr: 8'h00, data: 32'h1});
    foreach (words[i]) exp_q.push_back('{wr: 1'b1, addr: 8'h01, data: words[i]});
    exp_q.push_back('{wr: 1'b1, addr: 8'h00, data: 32'h2});
    for (int k = 0; k < da; k++) exp_q.push_back('{wr: 1'b0, addr: 8'h02, data: 32'h0});
    for (int i = 0; i < DIGEST_WORDS; i++)
      exp_q.push_back('{wr: 1'b0, addr: 8'(16 + i), data: 32'h0});
    check({tag, "_xact_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_xact%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    check({tag, "_dig_count"}, 64'(dig_got.size()), 64'(DIGEST_WORDS));
    for (int i = 0; i < dig_got.size() && i < DIGEST_WORDS; i++) begin
      check($sformatf("%s_dig%0d", tag, i), 64'(dig_got[i]), 64'(dig_tab[i]));
      check($sformatf("%s_last%0d", tag, i), 64'(last_got[i]), 64'(i == DIGEST_WORDS - 1));
    end
    for (int k = 1; k < status_start_cyc.size(); k++)
      check({tag, "_poll_spacing"},
            64'((status_start_cyc[k] - status_start_cyc[k-1]) >= POLL_GAP + 1), 64'(1));
    check({tag, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  initial begin : main
    logic [31:0] w[$];
    bit ok;
    reset = 1'b0;
    bus.msg_valid = 1'b0;
    bus.msg_data  = '0;
    bus.msg_last  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Single word, no stalls, DONE on first poll.
    rand_wait_pct = 0; ready_pct = 100;
    start_message(1);
    w = '{32'hDEAD_BEEF};
    push_word(w[0], 1'b1);
    finish_message("t1", w, 1);

    // First DATA write stalled 3 cycles: command held 4 cycles, each word written once.
    start_message(1);
    stall_addr = 1; stall_len = 3;
    w = '{$urandom, $urandom, $urandom};
    foreach (w[i]) push_word(w[i], i == w.size() - 1);
    finish_message("t2", w, 1);
    check("t2_hold_len", 64'(max_hold), 64'(4));

    // Six words back-to-back while the START write stalls 20 cycles.
    start_message(1);
    stall_addr = 0; stall_len = 20;
    w = '{};
    for (int i = 0; i < 6; i++) w.push_back($urandom);
    for (int i = 0; i < 4; i++) push_word(w[i], 1'b0);
    check("t3_full_ready", 64'(bus.msg_ready), 64'(0));
    push_word(w[4], 1'b0);
    push_word(w[5], 1'b1);
    finish_message("t3", w, 1);

    // STATUS returns DONE on the third read.
    start_message(3);
    w = '{$urandom, $urandom};
    foreach (w[i]) push_word(w[i], i == w.size() - 1);
    finish_message("t4", w, 3);

    // Consumer holds off digest word 7 for 5 cycles.
    start_message(1);
    hold_idx = 7; hold_len = 5;
    w = '{$urandom};
    push_word(w[0], 1'b1);
    finish_message("t5", w, 1);

    // Randomised messages with random bus stalls and consumer back-pressure.
    rand_wait_pct = 30; ready_pct = 60;
    for (int r = 0; r < 6; r++) begin
      int n, da;
      n  = int'($urandom_range(9, 1));
      da = int'($urandom_range(3, 1));
      start_message(da);
      w = '{};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      foreach (w[i]) push_word(w[i], i == w.size() - 1);
      finish_message($sformatf("rnd%0d", r), w, da);
    end

    // Reset asserted while a DATA write is stalled.
    rand_wait_pct = 0; ready_pct = 100;
    start_message(1);
    stall_addr = 1; stall_len = 30;
    w = '{$urandom, $urandom, $urandom};
    foreach (w[i]) push_word(w[i], i == w.size() - 1);
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      if (bus.avm_write && bus.avm_address == ADDR_W'(1)) begin
        ok = 1;
        break;
      end
      @(posedge clk); #2;
    end
    check("t6_reached_data", 64'(ok), 64'(1));
    #1 reset = 1'b0;
    #1 check_all_zero("t6_async");
    repeat (2) @(posedge clk);
    #2;
    stall_addr = -1;
    obs_q.delete();
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("t6_idle_busy", 64'(busy), 64'(0));
    check("t6_fifo_flushed", 64'(obs_q.size()), 64'(0));

`ifdef SHA3_POLL_TIMEOUT_EN
    // DONE never set: error after POLL_LIMIT reads, no digest, back to IDLE.
    start_message(1_000_000);
    push_word($urandom, 1'b1);
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      if (err) begin
        ok = 1;
        break;
      end
      @(posedge clk); #2;
    end
    check("to_err", 64'(err), 64'(1));
    check("to_idle", 64'(busy), 64'(0));
    check("to_polls", 64'(status_start_cyc.size()), 64'(POLL_LIMIT));
    check("to_no_digest", 64'(dig_got.size()), 64'(0));
    repeat (5) @(posedge clk);
    #2;
    check("to_err_sticky", 64'(err), 64'(1));
`else
    check("err_tied", 64'(err), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
